// File: rtl/sync_fifo.sv
// Single-clock standard-mode FIFO with registered full/empty and programmable almost-full/almost-empty flags.
// Latency: read data appears on dout one cycle after an accepted rd_en; flags update on the same edge as occupancy.
// Backpressure: writes while full and reads while empty are dropped; the optional SYNC_FIFO_FLAG_EN macro adds overflow/underflow pulses.
module sync_fifo #(
   parameter int unsigned WIDTH             = 32,
   parameter int unsigned DEPTH             = 512,
   parameter int unsigned PROG_FULL_THRESH  = 510,
   parameter int unsigned PROG_EMPTY_THRESH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             prog_full,
`ifdef SYNC_FIFO_FLAG_EN
   output logic             overflow,
   output logic             underflow,
`endif
   output logic             prog_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
   localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             wr_acc;
   logic             rd_acc;

   // Acceptance is qualified by the registered flags, so a full FIFO drops writes even when a read is also accepted.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   // Next-state occupancy; flags are derived from it so they move on the same edge as the counter.
   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage array is never reset; stale contents are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (wr_acc && !srst) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy, registered read data and status flags.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout       <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         prog_full  <= 1'b0;
         prog_empty <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         count      <= count_nxt;
         full       <= (count_nxt == DEPTH_C);
         empty      <= (count_nxt == '0);
         prog_full  <= (count_nxt >= PF_C);
         prog_empty <= (count_nxt <= PE_C);
      end
   end

`ifdef SYNC_FIFO_FLAG_EN
   // One-cycle error pulses for requests that were rejected at the previous edge.
   always_ff @(posedge clk) begin
      if (srst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed write/read/reset sequences driving a queue model.
// Latency: expected read words are queued at the edge and checked by a negedge monitor.
// Backpressure: model drops writes at full and reads at empty exactly like the design must.
module tb_sync_fifo;

   localparam int W     = 32;
   localparam int DEPTH = 512;
   localparam int PFT   = 510;
   localparam int PET   = 4;

   logic         clk = 1'b0;
   logic         srst = 1'b1;
   logic [W-1:0] din = '0;
   logic         wr_en = 1'b0;
   logic         rd_en = 1'b0;
   logic [W-1:0] dout;
   logic         full;
   logic         empty;
   logic         prog_full;
   logic         prog_empty;
`ifdef SYNC_FIFO_FLAG_EN
   logic         overflow;
   logic         underflow;
   int           unf_cnt = 0;
   int           ovf_cnt = 0;
`endif

   int total = 0;
   int bad   = 0;

   // Bench model state
   logic [W-1:0] model_q[$];
   logic [W-1:0] exp_q[$];
   int           mcount     = 0;
   bit           rd_pending = 0;
   bit           rst_pend   = 0;
   bit           exp_ovf    = 0;
   bit           exp_unf    = 0;
   bit           mon_en     = 0;
   logic [W-1:0] last_exp   = '0;

   sync_fifo #(
      .WIDTH(W),
      .DEPTH(DEPTH),
      .PROG_FULL_THRESH(PFT),
      .PROG_EMPTY_THRESH(PET)
   ) dut (
      .clk(clk),
      .srst(srst),
      .din(din),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .dout(dout),
      .full(full),
      .empty(empty),
      .prog_full(prog_full),
`ifdef SYNC_FIFO_FLAG_EN
      .overflow(overflow),
      .underflow(underflow),
`endif
      .prog_empty(prog_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model is advanced from its own occupancy, never from DUT outputs.
   task automatic cycle(input logic rst, input logic w, input logic [W-1:0] d, input logic r);
      bit wacc;
      bit racc;
      srst  = rst;
      wr_en = w;
      din   = d;
      rd_en = r;
      @(posedge clk);
      if (rst) begin
         model_q.delete();
         exp_q.delete();
         mcount     = 0;
         rd_pending = 0;
         rst_pend   = 1;
         exp_ovf    = 0;
         exp_unf    = 0;
      end else begin
         wacc    = w && (mcount < DEPTH);
         racc    = r && (mcount > 0);
         exp_ovf = w && (mcount == DEPTH);
         exp_unf = r && (mcount == 0);
         if (racc) exp_q.push_back(model_q.pop_front());
         if (wacc) model_q.push_back(d);
         mcount     = mcount + int'(wacc) - int'(racc);
         rd_pending = racc;
         rst_pend   = 0;
      end
      mon_en = 1;
      #1;
   endtask

   // Monitor: pops the scoreboard whenever a read was accepted and checks outputs every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_pend) last_exp = '0;
         if (rd_pending) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else last_exp = exp_q.pop_front();
         end
         chk("dout", dout, last_exp);
         chk("full", full, (mcount == DEPTH));
         chk("empty", empty, (mcount == 0));
         chk("prog_full", prog_full, (mcount >= PFT));
         chk("prog_empty", prog_empty, (mcount <= PET));
`ifdef SYNC_FIFO_FLAG_EN
         chk("overflow", overflow, exp_ovf);
         chk("underflow", underflow, exp_unf);
         if (underflow === 1'b1) unf_cnt++;
         if (overflow === 1'b1) ovf_cnt++;
`endif
      end
   end

   initial begin
      // 1: reset then idle
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_prog_empty", prog_empty, 1);
      chk("rst_prog_full", prog_full, 0);
      chk("rst_dout", dout, 0);

      // 2: write 0..512, last one must be dropped
      for (int i = 0; i < 513; i++) begin
         cycle(0, 1, W'(i), 0);
         if (i == 3) chk("prog_empty_after_4", prog_empty, 1);
         if (i == 4) chk("prog_empty_after_5", prog_empty, 0);
         if (i == 508) chk("prog_full_after_509", prog_full, 0);
         if (i == 509) chk("prog_full_after_510", prog_full, 1);
         if (i == 510) chk("full_after_511", full, 0);
         if (i == 511) chk("full_after_512", full, 1);
      end
      chk("full_hold", full, 1);
      chk("not_empty", empty, 0);
      cycle(0, 0, 0, 0);
`ifdef SYNC_FIFO_FLAG_EN
      chk("overflow_pulses", ovf_cnt, 1);
`endif

      // 3: read 20 from full
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0, 1);
         if (i == 0) chk("full_clears", full, 0);
      end
      chk("dout_19", dout, 19);

      // 4: read 100 more
      for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1);
      chk("dout_119", dout, 119);
      chk("prog_full_392", prog_full, 0);

      // 5: drain the remaining 392, then 3 reads of an empty FIFO
      for (int i = 0; i < 392; i++) cycle(0, 0, 0, 1);
      chk("empty_after_drain", empty, 1);
      chk("dout_511", dout, 511);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      chk("dout_hold_511", dout, 511);
`ifdef SYNC_FIFO_FLAG_EN
      chk("underflow_pulses", unf_cnt, 3);
`endif

      // 6: fill to 256, stream read+write, then reset mid-stream
      for (int i = 0; i < 256; i++) cycle(0, 1, W'(32'h100 + i), 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, W'(32'h200 + i), 1);
      chk("stream_dout", dout, 32'h113);
      chk("stream_full", full, 0);
      chk("stream_empty", empty, 0);
      chk("stream_prog_full", prog_full, 0);
      chk("stream_prog_empty", prog_empty, 0);
      cycle(1, 1, 32'h300, 1);
      chk("midrst_empty", empty, 1);
      chk("midrst_dout", dout, 0);
      cycle(0, 1, 32'hAA, 0);
      cycle(0, 1, 32'hBB, 0);
      cycle(0, 0, 0, 1);
      chk("post_rst_first", dout, 32'hAA);
      cycle(0, 0, 0, 1);
      chk("post_rst_second", dout, 32'hBB);
      chk("post_rst_empty", empty, 1);
      cycle(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
